// File: rtl/booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mul_arbiter
//
// Shares one external WIDTH-bit sequential Booth multiplier between two
// requesters. A round-robin grant picks one requester, its operands are
// latched, the multiplier is loaded for one cycle and then allowed WIDTH
// Booth steps. The product is captured and returned with a one-cycle ack
// to the owning requester.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (also forwarded as mul_rst)
//   req0/req1  level requests from requester 0 / 1
//   a0,b0      signed multiplicand / multiplier of requester 0
//   a1,b1      signed multiplicand / multiplier of requester 1
//   ack        one-cycle completion pulse, bit i belongs to requester i
//   res_p      signed product of the last completed operation
//   busy       high from the cycle after grant until the ack cycle
//   mul_a      multiplicand driven to the multiplier
//   mul_b      multiplier operand driven to the multiplier
//   mul_load   one-cycle load strobe to the multiplier
//   mul_rst    multiplier reset, combinational copy of rst
//   mul_p      product register of the multiplier
//   err        sticky self-check flag
//
// Optional feature macro: BOOTH_ARB_CHECK_EN
//   When defined, the captured multiplier product is compared against a
//   behavioural product of the latched operands and a mismatch sets err
//   until reset. When undefined, err is tied low.
// ---------------------------------------------------------------------------
module booth_mul_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [WIDTH-1:0]     a0,
   input  logic [WIDTH-1:0]     b0,
   input  logic [WIDTH-1:0]     a1,
   input  logic [WIDTH-1:0]     b1,
   output logic [1:0]           ack,
   output logic [2*WIDTH-1:0]   res_p,
   output logic                 busy,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   output logic                 mul_load,
   output logic                 mul_rst,
   input  logic [2*WIDTH-1:0]   mul_p,
   output logic                 err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 owner_q, owner_d;
   logic                 lastGrant_q, lastGrant_d;
   logic [WIDTH-1:0]     opA_q, opA_d;
   logic [WIDTH-1:0]     opB_q, opB_d;
   logic [1:0]           ack_q, ack_d;
   logic [2*WIDTH-1:0]   resP_q, resP_d;
   logic                 busy_q, busy_d;

   logic                 elig0, elig1, anyElig, pick1;

   // A requester that is being acked this cycle is not eligible, so a
   // request still held high from the finished job is not granted again.
   // On a tie the requester that did not win last time is picked.
   always_comb begin
      elig0   = req0 & ~ack_q[0];
      elig1   = req1 & ~ack_q[1];
      anyElig = elig0 | elig1;
      pick1   = elig1 & (~elig0 | ~lastGrant_q);
   end

   // Next-state and datapath update for the grant/load/run/done sequence.
   // The step counter runs from 0 to WIDTH-1 in RUN, giving the multiplier
   // exactly WIDTH steps before the product is captured in DONE.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      owner_d     = owner_q;
      lastGrant_d = lastGrant_q;
      opA_d       = opA_q;
      opB_d       = opB_q;
      ack_d       = 2'b00;
      resP_d      = resP_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (anyElig) begin
               owner_d = pick1;
               opA_d   = pick1 ? a1 : a0;
               opB_d   = pick1 ? b1 : b0;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            count_d = '0;
            state_d = RUN;
         end
         RUN: begin
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            resP_d         = mul_p;
            ack_d[owner_q] = 1'b1;
            lastGrant_d    = owner_q;
            busy_d         = 1'b0;
            state_d        = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight job without an ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         owner_q     <= 1'b0;
         lastGrant_q <= 1'b1;
         opA_q       <= '0;
         opB_q       <= '0;
         ack_q       <= 2'b00;
         resP_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         owner_q     <= owner_d;
         lastGrant_q <= lastGrant_d;
         opA_q       <= opA_d;
         opB_q       <= opB_d;
         ack_q       <= ack_d;
         resP_q      <= resP_d;
         busy_q      <= busy_d;
      end
   end

`ifdef BOOTH_ARB_CHECK_EN
   logic                 err_q, err_d;
   logic [2*WIDTH-1:0]   refProd;
   logic                 opAIsMin;

   // Sign-extended operands multiplied at full width; the low 2*WIDTH bits
   // are the exact signed product. The most negative multiplicand is known
   // to overflow the Booth accumulator, so it is excluded from the check.
   always_comb begin
      refProd  = {{WIDTH{opA_q[WIDTH-1]}}, opA_q} * {{WIDTH{opB_q[WIDTH-1]}}, opB_q};
      opAIsMin = (opA_q == {1'b1, {(WIDTH-1){1'b0}}});
      err_d    = err_q | ((state_q == DONE) & ~opAIsMin & (mul_p != refProd));
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign mul_load = (state_q == LOAD);
   assign mul_a    = opA_q;
   assign mul_b    = opB_q;
   assign mul_rst  = rst;
   assign ack      = ack_q;
   assign res_p    = resP_q;
   assign busy     = busy_q;

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one 8-bit sequential Booth multiplier between two requesters. It grants one request at a time, latches the granted operands, and pulses the multiplier's load for one cycle. It then counts the Booth steps, captures the 16-bit signed product and returns it with a one-cycle acknowledge to the owning requester. The block sits between the requesters and the multiplier instance, and is the only driver of the multiplier's control inputs.

## Interface
- WIDTH, 8, operand width; the multiplier performs exactly WIDTH Booth steps after load.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1 each  level request from requester 0 / 1.
- a0, b0, a1, b1  in  WIDTH each  signed multiplicand (a) and multiplier (b) per requester.
- ack  out  2  one-cycle completion pulse; bit i goes to requester i.
- res_p  out  2*WIDTH  signed product of the last completed operation.
- busy  out  1  high from grant until the ack cycle (exclusive).
- mul_a, mul_b  out  WIDTH each  operands to the multiplier (A, B).
- mul_load  out  1  multiplier load strobe.
- mul_rst  out  1  multiplier reset; equals rst combinationally.
- mul_p  in  2*WIDTH  multiplier product register.
- err  out  1  sticky self-check flag (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Samples req0/req1.
  - If any request is eligible, grants it, latches that requester's a/b into op_a/op_b, records owner, and goes to LOAD.
  - Otherwise stays in IDLE.
- Arbitration:
  - One eligible requester is granted.
  - If both are eligible, the requester not granted last time wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Eligibility: req[i] is ignored in any cycle where ack[i]=1, so a held request is not re-granted by accident.
- LOAD: mul_load=1; mul_a=op_a, mul_b=op_b; step counter cleared; next state RUN.
- RUN: mul_load=0; counter increments every cycle; after WIDTH cycles (counter = WIDTH-1) goes to DONE.
- DONE: on the edge that leaves DONE, res_p <= mul_p, ack[owner] <= 1, last_grant <= owner, busy <= 0; next state IDLE.
- mul_a/mul_b hold op_a/op_b in all states. Outside LOAD, mul_load=0.
- The requester keeps its operands stable only until the grant edge; later changes are ignored.
- Arithmetic:
  - Two's-complement signed operands; product is 2*WIDTH bits signed.
  - Supported multiplicand range is -(2^(WIDTH-1))+1 .. 2^(WIDTH-1)-1.
  - a = -2^(WIDTH-1) overflows the multiplier accumulator and yields an undefined res_p. The arbiter does not block it.
- Reset mid-operation:
  - rst forces IDLE, clears counter, owner, op_a/op_b, ack, busy, res_p and err, and sets last_grant=1.
  - The in-flight operation is dropped: no ack is produced for it.
  - mul_rst follows rst in the same cycle.
- rst has priority over every other event.

## Timing
- Reset values: ack=0, res_p=0, busy=0, mul_load=0, mul_a=0, mul_b=0, err=0.
- Cycle 0: IDLE samples req; grant edge.
- Cycle 1: LOAD (mul_load=1).
- Cycles 2..WIDTH+1: RUN.
- Cycle WIDTH+2: DONE.
- Cycle WIDTH+3: ack[owner]=1 and res_p is valid; the FSM is in IDLE.
- Latency from req sampled to ack: WIDTH+3 cycles (11 for WIDTH=8).
- A competing requester can be granted in the ack cycle, giving back-to-back grants every WIDTH+3 cycles.
- busy is high from cycle 1 through cycle WIDTH+2.
- res_p holds its value until the next ack.

## Configuration
- BOOTH_ARB_CHECK_EN defined:
  - In DONE, mul_p is compared with the behavioural signed product op_a*op_b.
  - A mismatch sets err sticky until rst.
  - The check is skipped when op_a = -2^(WIDTH-1).
- BOOTH_ARB_CHECK_EN undefined: the comparison logic is absent and err is tied to 0.

## Test plan
- Single request: req0, a0=3, b0=5 at cycle 0 -> mul_load high in cycle 1 only; ack=2'b01 in cycle 11; res_p=16'h000F; busy high in cycles 1-10.
- Signed operands: req1, a1=-7 (8'hF9), b1=6 -> ack=2'b10 after 11 cycles; res_p=16'hFFD6 (-42).
- Simultaneous requests after reset: req0 (a0=-8, b0=-128) and req1 (a1=127, b1=-1) both held.
  - Requester 0 first: ack[0] at cycle 11, res_p=16'h0400.
  - Requester 1 granted at cycle 11: ack[1] at cycle 22, res_p=16'hFF81.
- Fairness: both requests held continuously for 6 operations -> ack sequence 0,1,0,1,0,1; no ack is ever issued to a requester twice in a row while the other is requesting.
- Reset mid-operation: rst for one cycle at cycle 5 of a req0 (3x5) run.
  - No ack; busy=0 and res_p=0 in the following cycle.
  - A new req1 (2x2) then completes with res_p=16'h0004 after 11 cycles.
- With BOOTH_ARB_CHECK_EN: the bench forces mul_p=16'h1234 during DONE of 3x5 -> err=1 from the ack cycle onward, held until rst. Without the macro: err stays 0.
